// File: rtl/ifetch_unit_if.sv
// Fetch-side bus of ifetch_unit: instruction ROM port, redirect input and decode handshake.
// master = fetch unit, slave = ROM/branch/decode environment.
interface ifetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        fetch_fault;

    modport master (
        output imem_addr, inst_valid, inst_out, inst_pc, inst_pc4, fetch_fault,
        input  imem_data, redirect_valid, redirect_target, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_out, inst_pc, inst_pc4, fetch_fault,
        output imem_data, redirect_valid, redirect_target, inst_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, 2-entry in-order instruction buffer, redirects and sticky address fault.
// Define IFETCH_BYPASS_EN to forward a fetched word straight to decode when the buffer is empty.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [23:0] BASE_ADDRESS = 24'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_unit_if.master bus
);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] inst_q [2];
    logic [31:0] inst_d [2];
    logic [31:0] ipc_q  [2];
    logic [31:0] ipc_d  [2];

    logic        running;
    logic        in_window;
    logic        aligned;
    logic        buf_pop;
    logic        fetch;
    logic        bypass_take;
    logic        push;
    logic        wr_idx;
    logic [31:0] head_pc;

    assign in_window = (pc_q[31:8] == BASE_ADDRESS);
    assign aligned   = (pc_q[1:0] == 2'b00);
    assign buf_pop   = running && (count_q != 2'd0) && bus.inst_ready;
    assign fetch     = running && !bus.redirect_valid && in_window && aligned
                       && ((count_q != 2'd2) || buf_pop);
`ifdef IFETCH_BYPASS_EN
    assign bypass_take = fetch && (count_q == 2'd0) && bus.inst_ready;
`else
    assign bypass_take = 1'b0;
`endif
    assign push      = fetch && !bypass_take;
    // Slot for the new word once the head has (possibly) shifted out.
    assign wr_idx    = count_q[0] ^ buf_pop;
    assign bus.imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (bus.redirect_valid) begin
                if (bus.redirect_target[1:0] != 2'b00) begin
                    state_d = ST_FAULT;
                end
            end else if (!in_window) begin
                state_d = ST_FAULT;
            end
        end
    end

    always_comb begin
        running         = (state_q == ST_RUN);
        bus.fetch_fault = (state_q == ST_FAULT);
    end

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        if (running) begin
            if (bus.redirect_valid) begin
                pc_d    = bus.redirect_target;
                count_d = 2'd0;
            end else if (!in_window) begin
                count_d = 2'd0;
            end else begin
                if (buf_pop) begin
                    inst_d[0] = inst_q[1];
                    ipc_d[0]  = ipc_q[1];
                end
                if (push) begin
                    inst_d[wr_idx] = bus.imem_data;
                    ipc_d[wr_idx]  = pc_q;
                end
                if (fetch) begin
                    pc_d = pc_q + 32'd4;
                end
                count_d = count_q - {1'b0, buf_pop} + {1'b0, push};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inst_q[gi] <= 32'd0;
                    ipc_q[gi]  <= 32'd0;
                end else begin
                    inst_q[gi] <= inst_d[gi];
                    ipc_q[gi]  <= ipc_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        bus.inst_valid = running && (count_q != 2'd0);
        bus.inst_out   = inst_q[0];
        head_pc        = ipc_q[0];
`ifdef IFETCH_BYPASS_EN
        if ((count_q == 2'd0) && fetch) begin
            bus.inst_valid = 1'b1;
            bus.inst_out   = bus.imem_data;
            head_pc        = pc_q;
        end
`endif
        bus.inst_pc  = head_pc;
        bus.inst_pc4 = head_pc + 32'd4;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-level reference model compared every cycle plus directed scenarios.
module tb_ifetch_unit;

`ifdef IFETCH_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifetch_unit_if bus();

    ifetch_unit #(
        .RESET_PC     (32'h0000_0000),
        .BASE_ADDRESS (24'd0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] rom [64];
    assign bus.imem_data = (bus.imem_addr[31:8] == 24'd0) ? rom[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: PC, sticky fault flag and the buffered instructions as queues.
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] mq_pc [$];
    logic [31:0] mq_inst [$];

    // Instructions actually accepted by decode.
    logic [31:0] g_pc [$];
    logic [31:0] g_inst [$];
    logic [31:0] g_pc4 [$];

    logic        s_valid, s_fault;
    logic [31:0] s_addr;
    logic        e_fetch, e_head_fetched, e_valid;
    logic [31:0] e_hpc, e_hinst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return rom[a[7:2]];
    endfunction

    task automatic m_reset();
        m_pc    = 32'h0;
        m_fault = 1'b0;
        mq_pc.delete();
        mq_inst.delete();
    endtask

    task automatic g_clear();
        g_pc.delete();
        g_inst.delete();
        g_pc4.delete();
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic cyc();
        @(negedge clk);
        s_valid = bus.inst_valid;
        s_addr  = bus.imem_addr;
        s_fault = bus.fetch_fault;
        if (!rst_n) begin
            chk("reset_addr",  bus.imem_addr,   32'h0);
            chk("reset_valid", bus.inst_valid,  32'h0);
            chk("reset_fault", bus.fetch_fault, 32'h0);
            chk("reset_out",   bus.inst_out,    32'h0);
            chk("reset_pc",    bus.inst_pc,     32'h0);
            chk("reset_pc4",   bus.inst_pc4,    32'h4);
        end else begin
            e_fetch = !m_fault && !bus.redirect_valid && (m_pc[31:8] == 24'd0) && (m_pc[1:0] == 2'b00)
                      && ((mq_pc.size() < 2) || bus.inst_ready);
            e_head_fetched = (BYP != 0) && (mq_pc.size() == 0) && e_fetch;
            e_valid = !m_fault && ((mq_pc.size() > 0) || e_head_fetched);
            e_hpc   = 32'h0;
            e_hinst = 32'h0;
            if (e_head_fetched) begin
                e_hpc   = m_pc;
                e_hinst = rom_word(m_pc);
            end else if (mq_pc.size() > 0) begin
                e_hpc   = mq_pc[0];
                e_hinst = mq_inst[0];
            end
            chk("imem_addr",   bus.imem_addr,   m_pc);
            chk("fetch_fault", bus.fetch_fault, {31'd0, m_fault});
            chk("inst_valid",  bus.inst_valid,  {31'd0, e_valid});
            if (e_valid) begin
                chk("inst_pc",  bus.inst_pc,  e_hpc);
                chk("inst_out", bus.inst_out, e_hinst);
                chk("inst_pc4", bus.inst_pc4, e_hpc + 32'd4);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                g_pc.push_back(bus.inst_pc);
                g_inst.push_back(bus.inst_out);
                g_pc4.push_back(bus.inst_pc4);
                $display("t=%0t accept pc=%h inst=%h", $time, bus.inst_pc, bus.inst_out);
            end
        end
        @(posedge clk);
        if (rst_n && !m_fault) begin
            if (bus.redirect_valid) begin
                mq_pc.delete();
                mq_inst.delete();
                m_pc = bus.redirect_target;
                if (bus.redirect_target[1:0] != 2'b00) m_fault = 1'b1;
            end else if (m_pc[31:8] != 24'd0) begin
                m_fault = 1'b1;
                mq_pc.delete();
                mq_inst.delete();
            end else begin
                if (e_valid && bus.inst_ready && !e_head_fetched) begin
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (e_fetch && !(e_head_fetched && bus.inst_ready)) begin
                    mq_pc.push_back(m_pc);
                    mq_inst.push_back(rom_word(m_pc));
                end
                if (e_fetch) m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        cyc();
        rst_n = 1'b1;
        g_clear();
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 64; i++) rom[i] = 32'h2400_0000 | i;
        rom[0] = 32'h8C02_0004;
        rom[1] = 32'h0042_1020;
        rom[7] = 32'h0042_1020;

        rst_n = 1'b0;
        bus.inst_ready      = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        m_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        g_clear();

        // Startup
        repeat (6) cyc();
        chk("start_len", {31'd0, g_pc.size() >= 3}, 32'd1);
        if (g_pc.size() >= 3) begin
            chk("start0_pc",   g_pc[0],   32'h0);
            chk("start0_inst", g_inst[0], 32'h8C02_0004);
            chk("start1_pc",   g_pc[1],   32'h4);
            chk("start1_inst", g_inst[1], 32'h0042_1020);
            chk("start2_pc",   g_pc[2],   32'h8);
        end

        // Backpressure
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (5) cyc();
        chk("bp_addr",  s_addr, 32'h8);
        chk("bp_valid", {31'd0, s_valid}, 32'd1);
        bus.inst_ready = 1'b1;
        g_clear();
        repeat (3) cyc();
        chk("bp_len", g_pc.size(), 32'd3);
        if (g_pc.size() >= 3) begin
            chk("bp0_pc", g_pc[0], 32'h0);
            chk("bp1_pc", g_pc[1], 32'h4);
            chk("bp2_pc", g_pc[2], 32'h8);
        end

        // Redirect with full buffer and pop
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (3) cyc();
        bus.inst_ready      = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h1C;
        cyc();
        bus.redirect_valid = 1'b0;
        g_clear();
        cyc();
        chk("redir_valid_n1", {31'd0, s_valid}, BYP);
        cyc();
        chk("redir_len", {31'd0, g_pc.size() >= 1}, 32'd1);
        if (g_pc.size() >= 1) begin
            chk("redir_pc",   g_pc[0],   32'h1C);
            chk("redir_inst", g_inst[0], 32'h0042_1020);
            chk("redir_pc4",  g_pc4[0],  32'h20);
        end

        // Unaligned redirect
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h1E;
        cyc();
        bus.redirect_valid = 1'b0;
        cyc();
        chk("ua_fault", {31'd0, s_fault}, 32'd1);
        nv = 0;
        repeat (11) begin
            cyc();
            if (s_valid) nv++;
        end
        chk("ua_novalid",    nv, 32'd0);
        chk("ua_fault_hold", {31'd0, s_fault}, 32'd1);
        chk("ua_addr",       s_addr, 32'h1E);
        do_reset();
        cyc();
        cyc();
        chk("ua_recover_fault", {31'd0, s_fault}, 32'd0);
        chk("ua_recover_len", {31'd0, g_pc.size() >= 1}, 32'd1);
        if (g_pc.size() >= 1) chk("ua_recover_pc", g_pc[0], 32'h0);

        // Window end
        do_reset();
        repeat (70) cyc();
        chk("we_len",   g_pc.size(), 32'd64);
        if (g_pc.size() >= 1) chk("we_last", g_pc[g_pc.size() - 1], 32'hFC);
        chk("we_fault", {31'd0, s_fault}, 32'd1);
        chk("we_addr",  s_addr, 32'h100);

        // Async reset mid-run
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (3) cyc();
        chk("ar_pre_valid", {31'd0, bus.inst_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("ar_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("ar_addr",  bus.imem_addr, 32'h0);
        chk("ar_fault", {31'd0, bus.fetch_fault}, 32'd0);
        cyc();
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        g_clear();
        repeat (4) cyc();
        chk("ar_resume_len", {31'd0, g_pc.size() >= 1}, 32'd1);
        if (g_pc.size() >= 1) chk("ar_resume_pc", g_pc[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
